// File: rtl/vector_accumulator_if.sv
// Handshake bundle for vector_accumulator.
//  start/num_terms : job launch (master -> accumulator)
//  in_valid/in_ready/in_vec : scaled-vector input stream
//  out_valid/out_ready/out_vec : finished pre-activation vector
//  busy/ovf : job status (accumulator -> master)
// master = the side that launches jobs and feeds vectors; slave = the accumulator.
interface vector_accumulator_if #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned MAX_NEURONS = 4
);
  logic                                    start;
  logic [CNT_W-1:0]                        num_terms;
  logic                                    in_valid;
  logic                                    in_ready;
  logic [MAX_NEURONS-1:0][DATA_W-1:0]      in_vec;
  logic                                    out_valid;
  logic                                    out_ready;
  logic [MAX_NEURONS-1:0][DATA_W-1:0]      out_vec;
  logic                                    busy;
  logic                                    ovf;

  modport master (
    output start, num_terms, in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_vec, busy, ovf
  );

  modport slave (
    input  start, num_terms, in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_vec, busy, ovf
  );
endinterface

// File: rtl/vector_accumulator.sv
// vector_accumulator
//  Sums num_terms sign-magnitude scaled vectors lane by lane with saturation,
//  then presents the finished vector until downstream accepts it.
// Ports
//  clk : system clock, rising edge
//  rst : asynchronous reset, active-high
//  bus : vector_accumulator_if.slave (start/num_terms, in_* stream,
//        out_* stream, busy, ovf)
// Lane format: bit DATA_W-1 is the sign, the rest is magnitude; FRAC_W
// fractional bits (1.0 = 1 << FRAC_W). Zero results are always +0.
module vector_accumulator #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned FRAC_W      = 15,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned MAX_NEURONS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  vector_accumulator_if.slave  bus
);

  localparam int unsigned MW = DATA_W - 1;

  if (FRAC_W >= MW) begin : g_bad_frac
    $error("FRAC_W must leave at least one integer magnitude bit");
  end

  typedef logic [DATA_W-1:0]               lane_t;
  typedef lane_t [MAX_NEURONS-1:0]         vec_t;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                   state, state_nxt;
  vec_t                     acc, acc_nxt, sum;
  logic [MAX_NEURONS-1:0]   lane_ovf;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic                     ovf_r, ovf_nxt;

  // Returns {saturated, result}.
  function automatic logic [DATA_W:0] sat_add(input lane_t a, input lane_t b);
    logic [MW:0]   s;
    logic [MW-1:0] mag;
    logic          sgn;
    logic          ov;
    s   = '0;
    ov  = 1'b0;
    if (a[MW] == b[MW]) begin
      s   = {1'b0, a[MW-1:0]} + {1'b0, b[MW-1:0]};
      sgn = a[MW];
      if (s[MW]) begin
        mag = '1;
        ov  = 1'b1;
      end else begin
        mag = s[MW-1:0];
      end
    end else if (a[MW-1:0] >= b[MW-1:0]) begin
      mag = a[MW-1:0] - b[MW-1:0];
      sgn = a[MW];
    end else begin
      mag = b[MW-1:0] - a[MW-1:0];
      sgn = b[MW];
    end
    if (mag == '0) sgn = 1'b0;
    return {ov, sgn, mag};
  endfunction

  always_comb begin
    sum      = '0;
    lane_ovf = '0;
    for (int unsigned i = 0; i < MAX_NEURONS; i++) begin
      {lane_ovf[i], sum[i]} = sat_add(acc[i], bus.in_vec[i]);
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf_r;
    case (state)
      IDLE: begin
        if (bus.start) begin
          acc_nxt = '0;
          ovf_nxt = 1'b0;
          if (bus.num_terms != '0) begin
            cnt_nxt   = bus.num_terms;
            state_nxt = ACCUM;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      ACCUM: begin
        // in_ready is high throughout ACCUM, so in_valid alone is the handshake.
        if (bus.in_valid) begin
          acc_nxt = sum;
          ovf_nxt = ovf_r | (|lane_ovf);
          cnt_nxt = cnt - 1'b1;
          if (cnt == CNT_W'(1)) state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      ovf_r <= 1'b0;
    end else begin
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      ovf_r <= ovf_nxt;
    end
  end

  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_vec   = acc;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_vector_accumulator.sv
module tb_vector_accumulator;

  localparam int unsigned LANES = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = 8;

  typedef logic [LANES*DW-1:0] flat_t;
  typedef struct {
    flat_t vec;
    logic  ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vector_accumulator_if #(.DATA_W(DW), .CNT_W(CW), .MAX_NEURONS(LANES)) bus ();

  vector_accumulator #(
    .DATA_W(DW), .FRAC_W(15), .CNT_W(CW), .MAX_NEURONS(LANES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int          total  = 0;
  int          passed = 0;
  int          fails  = 0;
  logic [31:0] m_acc [LANES];
  logic        m_ovf;
  exp_t        sbq [$];

  task automatic chk(input string tag, input flat_t obs, input flat_t exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference add: signed integer sum clamped to +/-(2^31-1).
  function automatic logic [32:0] m_add(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, s;
    longint lim;
    logic   ov;
    lim = 64'sh7FFF_FFFF;
    sa = longint'({33'b0, a[30:0]}); if (a[31]) sa = -sa;
    sb = longint'({33'b0, b[30:0]}); if (b[31]) sb = -sb;
    s  = sa + sb;
    ov = 1'b0;
    if (s > lim) begin s = lim; ov = 1'b1; end
    else if (s < -lim) begin s = -lim; ov = 1'b1; end
    if (s < 0) return {ov, 1'b1, 31'(-s)};
    return {ov, 1'b0, 31'(s)};
  endfunction

  function automatic flat_t model_flat();
    flat_t f;
    for (int i = 0; i < LANES; i++) f[i*DW +: DW] = m_acc[i];
    return f;
  endfunction

  task automatic model_beat(input flat_t v);
    logic [32:0] r;
    for (int i = 0; i < LANES; i++) begin
      r = m_add(m_acc[i], v[i*DW +: DW]);
      m_acc[i] = r[31:0];
      if (r[32]) m_ovf = 1'b1;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.vec = model_flat();
    e.ovf = m_ovf;
    sbq.push_back(e);
  endtask

  task automatic start_job(input int n);
    bus.start     = 1'b1;
    bus.num_terms = CW'(n);
    for (int i = 0; i < LANES; i++) m_acc[i] = '0;
    m_ovf = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic beat(input flat_t v);
    chk("in_ready", flat_t'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_vec   = v;
    model_beat(v);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_out(input int limit, input string tag);
    exp_t e;
    int   w = 0;
    while (bus.out_valid !== 1'b1 && w < limit) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_valid"}, flat_t'(bus.out_valid), 1);
    if (sbq.size() == 0) begin
      total++;
      fails++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_vec"}, bus.out_vec, e.vec);
      chk({tag, "_ovf"}, flat_t'(bus.ovf), flat_t'(e.ovf));
    end
  endtask

  task automatic accept_out(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_valid_drop"}, flat_t'(bus.out_valid), 0);
    chk({tag, "_idle"}, flat_t'(bus.busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    flat_t v;
    exp_t  e;
    int    beats, cyc;

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.num_terms = '0;
    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  flat_t'(bus.in_ready), 0);
    chk("rst_out_valid", flat_t'(bus.out_valid), 0);
    chk("rst_busy",      flat_t'(bus.busy), 0);
    chk("rst_ovf",       flat_t'(bus.ovf), 0);
    chk("rst_out_vec",   bus.out_vec, 0);
    rst = 1'b0;
    @(negedge clk);

    // Three beats of 1.0 per lane, back-to-back.
    start_job(3);
    chk("t1_busy", flat_t'(bus.busy), 1);
    beat({4{32'h0000_8000}});
    beat({4{32'h0000_8000}});
    chk("t1_early_valid", flat_t'(bus.out_valid), 0);
    beat({4{32'h0000_8000}});
    push_exp();
    expect_out(0, "t1");
    chk("t1_const", bus.out_vec, {4{32'h0001_8000}});
    accept_out("t1");

    // Opposite-sign cancellation, including exact zero.
    start_job(2);
    beat({32'h0, 32'h0, 32'h8000_8000, 32'h0001_0000});
    beat({32'h0, 32'h0, 32'h0000_8000, 32'h8000_4000});
    push_exp();
    expect_out(0, "t2");
    chk("t2_const", bus.out_vec, {32'h0, 32'h0, 32'h0000_0000, 32'h0000_C000});
    accept_out("t2");

    // Positive and negative saturation.
    start_job(2);
    beat({32'h0, 32'h0, 32'hFFFF_FFF0, 32'h7FFF_FFFF});
    beat({32'h0, 32'h0, 32'h8000_0020, 32'h0000_0001});
    push_exp();
    expect_out(0, "t3");
    chk("t3_const", bus.out_vec, {32'h0, 32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF});
    chk("t3_ovf", flat_t'(bus.ovf), 1);
    accept_out("t3");

    // Zero-term job: result zero, ovf cleared by the new start.
    start_job(0);
    push_exp();
    expect_out(0, "t5");
    chk("t5_const", bus.out_vec, 0);
    accept_out("t5");

    // Random in_valid, downstream stall, start pulsed while DONE.
    start_job(4);
    beats = 0;
    cyc   = 0;
    while (beats < 4 && cyc < 200) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_vec   = {$urandom, $urandom, $urandom, $urandom};
      if (bus.in_valid && bus.in_ready) begin
        model_beat(bus.in_vec);
        beats++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("t4_beats", flat_t'(beats), 4);
    push_exp();
    e = sbq[0];
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_vec   = {$urandom, $urandom, $urandom, $urandom};
      if (k == 2) begin
        bus.start     = 1'b1;
        bus.num_terms = 8'd7;
      end
      chk("t4_hold_valid", flat_t'(bus.out_valid), 1);
      chk("t4_hold_vec", bus.out_vec, e.vec);
      chk("t4_hold_in_ready", flat_t'(bus.in_ready), 0);
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.in_valid = 1'b0;
    expect_out(0, "t4");
    accept_out("t4");
    chk("t4_acc_kept", bus.out_vec, e.vec);

    // Asynchronous reset in the middle of a job.
    start_job(4);
    beat({$urandom, $urandom, $urandom, $urandom});
    beat({$urandom, $urandom, $urandom, $urandom});
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_vec",      bus.out_vec, 0);
    chk("t6_rst_busy",     flat_t'(bus.busy), 0);
    chk("t6_rst_in_ready", flat_t'(bus.in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_no_valid", flat_t'(bus.out_valid), 0);
    start_job(1);
    beat({4{32'h0000_8000}});
    push_exp();
    expect_out(0, "t6");
    chk("t6_const", bus.out_vec, {4{32'h0000_8000}});
    accept_out("t6");

    chk("sb_drained", flat_t'(sbq.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
